// File: rtl/multi_alarm_scheduler.sv
// multi_alarm_scheduler: N weekday alarm channels with ring/timeout sequencing.
// Optional snooze state is built when ALARM_SNOOZE_EN is defined.
module multi_alarm_scheduler #(
  parameter int N_CH           = 4,
  parameter int CH_W           = 2,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      cur_hour,
  input  logic [5:0]      cur_min,
  input  logic [5:0]      cur_sec,
  input  logic [2:0]      cur_day,
  input  logic            wr_en,
  input  logic [CH_W-1:0] wr_ch,
  input  logic [5:0]      wr_hour,
  input  logic [5:0]      wr_min,
  input  logic [6:0]      wr_daymask,
  input  logic            wr_on,
  input  logic            ack,
  input  logic            snooze,
  output logic            ring,
  output logic [CH_W-1:0] ring_ch,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] missed
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RING = 2'd1,
    SNZ  = 2'd2
  } st_t;
`else
  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } st_t;
`endif

  localparam logic [7:0] RC_LOAD = 8'(RING_TIMEOUT_S);

  st_t             st_q   [N_CH];
  st_t             st_d   [N_CH];
  logic [7:0]      rcnt_q [N_CH];
  logic [7:0]      rcnt_d [N_CH];
  logic [5:0]      hr_q   [N_CH];
  logic [5:0]      mn_q   [N_CH];
  logic [6:0]      msk_q  [N_CH];
  logic [N_CH-1:0] on_q;
  logic [N_CH-1:0] miss_d;
  logic [N_CH-1:0] match;
  logic [N_CH-1:0] wr_hit;
  logic [N_CH-1:0] ack_hit;
  logic [N_CH-1:0] rmask_d;
  logic [N_CH-1:0] pmask_d;
  logic [CH_W-1:0] rch_d;
  logic [5:0]      sec_q;
  logic            sec_tick;
  logic            min_tick;
  logic            wr_ok;

`ifdef ALARM_SNOOZE_EN
  localparam logic [5:0] SC_LOAD = 6'(SNOOZE_MIN);

  logic [5:0]      scnt_q [N_CH];
  logic [5:0]      scnt_d [N_CH];
  logic [N_CH-1:0] snz_hit;
  logic [CH_W-1:0] lowp;
  logic [CH_W-1:0] tgt;
`else
  logic unused_snz;
  assign unused_snz = snooze | (SNOOZE_MIN == 0);
`endif

  assign sec_tick = cur_sec != sec_q;
  assign min_tick = sec_tick && (cur_sec == 6'd0);
  assign wr_ok    = wr_en && (wr_hour <= 6'd23)
                    && (wr_min <= 6'd59);

  // Registered copy of the seconds field for tick detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sec_q <= 6'd0;
    else        sec_q <= cur_sec;
  end

`ifdef ALARM_SNOOZE_EN
  // Lowest pending channel: ack target when nothing rings.
  always_comb begin
    lowp = '0;
    for (int i = N_CH-1; i >= 0; i--)
      if (pending[i]) lowp = CH_W'(i);
  end

  assign tgt = ring ? ring_ch : lowp;
`endif

  // Per-channel match, write and dismiss decode.
  always_comb begin
    match   = '0;
    wr_hit  = '0;
    ack_hit = '0;
`ifdef ALARM_SNOOZE_EN
    snz_hit = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      match[i] = min_tick && on_q[i]
        && (hr_q[i] == cur_hour)
        && (mn_q[i] == cur_min)
        && (|({1'b0, msk_q[i]} & (8'd1 << cur_day)));
      wr_hit[i] = wr_ok && (wr_ch == CH_W'(i));
`ifdef ALARM_SNOOZE_EN
      ack_hit[i] = ack && pending[i]
        && (tgt == CH_W'(i));
      snz_hit[i] = snooze && (st_q[i] == RING)
        && (ring_ch == CH_W'(i));
`else
      ack_hit[i] = ack && (st_q[i] == RING)
        && (ring_ch == CH_W'(i));
`endif
    end
  end

  // Channel state, counters and sticky missed flags.
  always_comb begin
    miss_d = missed;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]   = st_q[i];
      rcnt_d[i] = rcnt_q[i];
`ifdef ALARM_SNOOZE_EN
      scnt_d[i] = scnt_q[i];
`endif
      if (wr_hit[i]) begin
        st_d[i]   = IDLE;
        miss_d[i] = 1'b0;
      end else if (match[i]) begin
        st_d[i]   = RING;
        rcnt_d[i] = RC_LOAD;
        miss_d[i] = 1'b0;
      end else if (st_q[i] == RING) begin
        if (ack_hit[i]) begin
          st_d[i] = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snz_hit[i]) begin
          st_d[i]   = SNZ;
          scnt_d[i] = SC_LOAD;
`endif
        end else if (sec_tick) begin
          if (rcnt_q[i] == 8'd1) begin
            st_d[i]   = IDLE;
            miss_d[i] = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_q[i] - 8'd1;
          end
        end
`ifdef ALARM_SNOOZE_EN
      end else if (st_q[i] == SNZ) begin
        if (ack_hit[i]) begin
          st_d[i] = IDLE;
        end else if (min_tick) begin
          if (scnt_q[i] == 6'd1) begin
            st_d[i]   = RING;
            rcnt_d[i] = RC_LOAD;
          end else begin
            scnt_d[i] = scnt_q[i] - 6'd1;
          end
        end
`endif
      end
    end
  end

  // Output masks and lowest ringing channel from next state.
  always_comb begin
    rmask_d = '0;
    pmask_d = '0;
    rch_d   = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      rmask_d[i] = st_d[i] == RING;
      pmask_d[i] = st_d[i] != IDLE;
      if (st_d[i] == RING) rch_d = CH_W'(i);
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= IDLE;
        rcnt_q[i] <= 8'd0;
      end
      ring    <= 1'b0;
      ring_ch <= '0;
      pending <= '0;
      missed  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= st_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
      ring    <= |rmask_d;
      ring_ch <= rch_d;
      pending <= pmask_d;
      missed  <= miss_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze minute counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++)
        scnt_q[i] <= 6'd0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        scnt_q[i] <= scnt_d[i];
    end
  end
`endif

  // Channel configuration; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      on_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hr_q[i]  <= 6'd0;
        mn_q[i]  <= 6'd0;
        msk_q[i] <= 7'h7F;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_hit[i]) begin
          on_q[i]  <= wr_on;
          hr_q[i]  <= wr_hour;
          mn_q[i]  <= wr_min;
          msk_q[i] <= wr_daymask;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_alarm_scheduler.sv
// tb_multi_alarm_scheduler: directed scenarios plus random traffic
// checked every cycle against a behavioural alarm model.
module tb_multi_alarm_scheduler;
  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int TO   = 60;
  localparam int SNZ  = 5;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0]      cur_hour, cur_min, cur_sec;
  logic [2:0]      cur_day;
  logic            wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [5:0]      wr_hour, wr_min;
  logic [6:0]      wr_daymask;
  logic            wr_on, ack, snooze;
  logic            ring;
  logic [CH_W-1:0] ring_ch;
  logic [N_CH-1:0] pending, missed;

  always #5 clk = ~clk;

  multi_alarm_scheduler #(
    .N_CH(N_CH), .CH_W(CH_W),
    .RING_TIMEOUT_S(TO), .SNOOZE_MIN(SNZ)
  ) dut (
    .clk(clk), .reset(reset),
    .cur_hour(cur_hour), .cur_min(cur_min),
    .cur_sec(cur_sec), .cur_day(cur_day),
    .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_hour(wr_hour), .wr_min(wr_min),
    .wr_daymask(wr_daymask), .wr_on(wr_on),
    .ack(ack), .snooze(snooze),
    .ring(ring), .ring_ch(ring_ch),
    .pending(pending), .missed(missed)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // model: 0 idle, 1 ringing, 2 snoozed
  int       m_st      [N_CH];
  int       m_elapsed [N_CH];
  int       m_left    [N_CH];
  bit       m_missed  [N_CH];
  int       m_hr      [N_CH];
  int       m_mn      [N_CH];
  bit [6:0] m_msk     [N_CH];
  bit       m_on      [N_CH];
  int       m_prev_sec;

  task automatic check(input string nm,
                       input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_st[i] = 0; m_elapsed[i] = 0; m_left[i] = 0;
      m_missed[i] = 0; m_hr[i] = 0; m_mn[i] = 0;
      m_msk[i] = 7'h7F; m_on[i] = 0;
    end
    m_prev_sec = 0;
  endtask

  task automatic model_step();
    bit st, mt, wok, hit;
    int lr, lp, tgt;
    st = (int'(cur_sec) != m_prev_sec);
    mt = st && (cur_sec == 0);
    m_prev_sec = int'(cur_sec);
    lr = -1; lp = -1;
    for (int i = 0; i < N_CH; i++) begin
      if (m_st[i] == 1 && lr < 0) lr = i;
      if (m_st[i] != 0 && lp < 0) lp = i;
    end
    tgt = (lr >= 0) ? lr : lp;
    wok = wr_en && (wr_hour < 24) && (wr_min < 60);
    for (int i = 0; i < N_CH; i++) begin
      hit = mt && m_on[i] && (m_hr[i] == int'(cur_hour))
        && (m_mn[i] == int'(cur_min)) && (cur_day < 7)
        && m_msk[i][cur_day];
      if (wok && int'(wr_ch) == i) begin
        m_on[i] = wr_on; m_hr[i] = int'(wr_hour);
        m_mn[i] = int'(wr_min); m_msk[i] = wr_daymask;
        m_st[i] = 0; m_missed[i] = 0;
      end else if (hit) begin
        m_st[i] = 1; m_elapsed[i] = 0; m_missed[i] = 0;
      end else if (m_st[i] == 1) begin
        if (ack && i == tgt) m_st[i] = 0;
        else if (SNZ_EN && snooze && i == lr) begin
          m_st[i] = 2; m_left[i] = SNZ;
        end else if (st) begin
          m_elapsed[i]++;
          if (m_elapsed[i] == TO) begin
            m_st[i] = 0; m_missed[i] = 1;
          end
        end
      end else if (m_st[i] == 2) begin
        if (ack && i == tgt) m_st[i] = 0;
        else if (mt) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_st[i] = 1; m_elapsed[i] = 0;
          end
        end
      end
    end
  endtask

  // Compare DUT outputs with the model after every edge.
  always @(posedge clk) begin
    int er, ec, ep, em;
    #1;
    if (chk_en) begin
      er = 0; ec = 0; ep = 0; em = 0;
      for (int i = N_CH-1; i >= 0; i--) begin
        if (m_st[i] == 1) begin er = 1; ec = i; end
        if (m_st[i] != 0) ep |= (1 << i);
        if (m_missed[i]) em |= (1 << i);
      end
      check("ring", int'(ring), er);
      check("ring_ch", int'(ring_ch), ec);
      check("pending", int'(pending), ep);
      check("missed", int'(missed), em);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    wr_en = 1'b0; ack = 1'b0; snooze = 1'b0;
  endtask

  task automatic wr(input int ch, input int h, input int m,
                    input int mask, input bit on);
    wr_ch = CH_W'(ch); wr_hour = 6'(h); wr_min = 6'(m);
    wr_daymask = 7'(mask); wr_on = on; wr_en = 1'b1;
    tick();
  endtask

  task automatic set_time(input int h, input int m,
                          input int s, input int d);
    cur_hour = 6'(h); cur_min = 6'(m);
    cur_sec = 6'(s); cur_day = 3'(d);
    repeat (3) tick();
  endtask

  task automatic adv_sec();
    if (cur_sec == 6'd59) begin
      cur_sec = 6'd0;
      if (cur_min == 6'd59) begin
        cur_min = 6'd0;
        if (cur_hour == 6'd23) begin
          cur_hour = 6'd0;
          cur_day = (cur_day == 3'd6) ? 3'd0 : cur_day + 3'd1;
        end else cur_hour = cur_hour + 6'd1;
      end else cur_min = cur_min + 6'd1;
    end else cur_sec = cur_sec + 6'd1;
  endtask

  task automatic sec_step(input int ncyc);
    adv_sec();
    repeat (ncyc) tick();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
  endtask

  initial begin
    int base, t, nc;
    reset = 1'b1;
    cur_hour = 0; cur_min = 0; cur_sec = 0; cur_day = 0;
    wr_en = 0; wr_ch = 0; wr_hour = 0; wr_min = 0;
    wr_daymask = 0; wr_on = 0; ack = 0; snooze = 0;
    #2 reset = 1'b0;
    #1;
    check("rst_ring", int'(ring), 0);
    check("rst_ring_ch", int'(ring_ch), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_missed", int'(missed), 0);
    model_reset();
    chk_en = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // T1
    wr(0, 7, 30, 7'h7F, 1);
    set_time(7, 29, 59, 2);
    check("t1_pre_ring", int'(ring), 0);
    sec_step(1);
    check("t1_ring", int'(ring), 1);
    check("t1_ring_ch", int'(ring_ch), 0);
    check("t1_pending", int'(pending), 4'b0001);
    pulse_ack();
    check("t1_ack", int'(ring), 0);

    // T2
    wr(1, 6, 0, 7'h7F, 1);
    wr(2, 6, 0, 7'h7F, 1);
    set_time(5, 59, 59, 2);
    sec_step(2);
    check("t2_ring_ch", int'(ring_ch), 1);
    check("t2_pending", int'(pending), 4'b0110);
    pulse_ack();
    check("t2_ack1_ch", int'(ring_ch), 2);
    check("t2_ack1_ring", int'(ring), 1);
    pulse_ack();
    check("t2_ack2_ring", int'(ring), 0);
    check("t2_ack2_pend", int'(pending), 0);

    // T3
    set_time(7, 29, 59, 2);
    sec_step(2);
    check("t3_ring", int'(ring), 1);
    repeat (59) sec_step(2);
    check("t3_still", int'(ring), 1);
    sec_step(2);
    check("t3_timeout", int'(ring), 0);
    check("t3_missed", int'(missed), 4'b0001);
    set_time(7, 29, 59, 3);
    sec_step(2);
    check("t3_rering", int'(ring), 1);
    check("t3_miss_clr", int'(missed), 0);
    pulse_ack();

    // T5
    wr(3, 12, 0, 7'b0000001, 1);
    set_time(11, 59, 59, 3);
    sec_step(2);
    check("t5_wrong_day", int'(ring), 0);
    set_time(11, 59, 59, 0);
    sec_step(2);
    check("t5_day0", int'(ring), 1);
    check("t5_ch", int'(ring_ch), 3);
    pulse_ack();

    // midnight: new weekday applies to the 00:00 match
    wr(1, 0, 0, 7'b0100000, 1);
    set_time(23, 59, 59, 4);
    sec_step(2);
    check("mid_ring", int'(ring), 1);
    check("mid_ch", int'(ring_ch), 1);
    pulse_ack();

    // out-of-range writes leave ch2 at 06:00
    wr(2, 24, 0, 7'h00, 0);
    wr(2, 6, 60, 7'h00, 0);
    set_time(5, 59, 59, 1);
    sec_step(2);
    check("inv_ring_ch", int'(ring_ch), 2);
    check("inv_pending", int'(pending), 4'b0100);
    wr(2, 6, 0, 7'h7F, 1);
    check("wr_cancel", int'(ring), 0);
    check("wr_cancel_p", int'(pending), 0);

    wr(0, 8, 0, 7'h7F, 1);
`ifdef ALARM_SNOOZE_EN
    // T4
    set_time(7, 59, 59, 1);
    sec_step(2);
    repeat (10) sec_step(2);
    snooze = 1'b1;
    tick();
    check("t4_snz_ring", int'(ring), 0);
    check("t4_snz_pend", int'(pending), 4'b0001);
    while (!(cur_min == 6'd5 && cur_sec == 6'd0)) sec_step(1);
    tick();
    check("t4_rering", int'(ring), 1);
    pulse_ack();
`endif

    // T6
    set_time(7, 59, 59, 1);
    sec_step(2);
    check("t6_ring", int'(ring), 1);
    reset = 1'b0;
    #1;
    check("t6_rst_ring", int'(ring), 0);
    check("t6_rst_pend", int'(pending), 0);
    check("t6_rst_miss", int'(missed), 0);
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    set_time(7, 59, 59, 1);
    sec_step(2);
    check("t6_no_rering", int'(ring), 0);

    // random traffic
    for (int sc = 0; sc < 24; sc++) begin
      base = $urandom_range(0, 1439);
      cur_day = 3'($urandom_range(0, 6));
      for (int c = 0; c < N_CH; c++) begin
        t = (base + $urandom_range(0, 2)) % 1440;
        wr(c, t / 60, t % 60,
           int'($urandom_range(0, 127))
           | (($urandom_range(0, 1) == 1) ? (1 << cur_day) : 0),
           $urandom_range(0, 4) != 0);
      end
      t = (base + 1439) % 1440;
      set_time(t / 60, t % 60, 58, int'(cur_day));
      for (int s = 0; s < 200; s++) begin
        adv_sec();
        nc = $urandom_range(1, 3);
        for (int k = 0; k < nc; k++) begin
          ack = ($urandom_range(0, 7) == 0);
          snooze = ($urandom_range(0, 9) == 0);
          if ($urandom_range(0, 79) == 0) begin
            wr_ch = CH_W'($urandom_range(0, N_CH-1));
            wr_hour = 6'($urandom_range(0, 25));
            wr_min = 6'($urandom_range(0, 61));
            wr_daymask = 7'($urandom_range(0, 127));
            wr_on = 1'($urandom_range(0, 1));
            wr_en = 1'b1;
          end
          tick();
        end
      end
    end

    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
